// File: rtl/lm75_i2c_target.sv
// lm75_i2c_target: LM75-compatible I2C target exposing temperature, config, THYST and TOS registers.
module lm75_i2c_target #(
    parameter logic [6:0]  DEV_ADDR  = 7'b1001000,
    parameter logic [15:0] TOS_RST   = 16'h5000,
    parameter logic [15:0] THYST_RST = 16'h4B00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  cfg_out,
    output logic        busy
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_BYTE   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_BYTE   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic [1:0]  scl_s, sda_s, ptr, widx;
    logic        scl_d, sda_d, rw, hi, nack;
    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [7:0]  sr, tx, hold, rd_byte;
    logic [15:0] tos, thyst, snap, rd_word;
    logic        scl, sda, scl_rise, scl_fall, start, stop;

    always_comb begin
        scl      = scl_s[1];
        sda      = sda_s[1];
        scl_rise = scl & ~scl_d;
        scl_fall = ~scl & scl_d;
        start    = scl & scl_d & sda_d & ~sda;
        stop     = scl & scl_d & ~sda_d & sda;
        rd_word  = (ptr == 2'd0) ? snap : (ptr == 2'd2) ? thyst : tos;
        rd_byte  = (ptr == 2'd1) ? cfg_out : hi ? rd_word[15:8] : rd_word[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s   <= 2'b11;
            sda_s   <= 2'b11;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
            state   <= IDLE;
            cnt     <= 4'd0;
            sr      <= 8'h00;
            tx      <= 8'h00;
            hold    <= 8'h00;
            ptr     <= 2'd0;
            widx    <= 2'd0;
            rw      <= 1'b0;
            hi      <= 1'b1;
            nack    <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            cfg_out <= 8'h00;
            tos     <= TOS_RST;
            thyst   <= THYST_RST;
            snap    <= 16'h0000;
        end else begin
            scl_s <= {scl_s[0], scl_i};
            sda_s <= {sda_s[0], sda_i};
            scl_d <= scl;
            sda_d <= sda;
            if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state  <= ADDR;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            sr  <= {sr[6:0], sda};
                            cnt <= cnt + 4'd1;
                            // R/W bit of a matching read: freeze temperature for a coherent word
                            if (cnt == 4'd7 && sda && sr[6:0] == DEV_ADDR) snap <= temp_in;
                        end else if (scl_fall && cnt == 4'd8) begin
                            cnt <= 4'd0;
                            if (sr[7:1] == DEV_ADDR) begin
                                state  <= ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= sr[0];
                                hi     <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            state  <= rw ? RD_BYTE : WR_BYTE;
                            widx   <= 2'd0;
                            tx     <= rd_byte;
                            sda_oe <= rw & ~rd_byte[7];
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            sr  <= {sr[6:0], sda};
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            state  <= WR_ACK;
                            sda_oe <= 1'b1;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            state  <= WR_BYTE;
                            sda_oe <= 1'b0;
                            cnt    <= 4'd0;
                            widx   <= (widx == 2'd3) ? 2'd3 : widx + 2'd1;
                            // 16-bit limits are staged in hold and committed together on the LSB
                            if (widx == 2'd0) ptr <= sr[1:0];
                            else if (widx == 2'd1 && ptr == 2'd1) cfg_out <= sr;
                            else if (widx == 2'd1) hold <= sr;
                            else if (widx == 2'd2 && ptr == 2'd2) thyst <= {hold, sr};
                            else if (widx == 2'd2 && ptr == 2'd3) tos <= {hold, sr};
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                state  <= RD_ACK;
                                sda_oe <= 1'b0;
                                hi     <= ~hi;
                            end else begin
                                tx     <= {tx[6:0], 1'b0};
                                sda_oe <= ~tx[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack <= sda;
                        end else if (scl_fall) begin
                            cnt <= 4'd0;
                            if (nack) begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end else begin
                                state  <= RD_BYTE;
                                tx     <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lm75_i2c_target.sv
// tb_lm75_i2c_target: bit-banged I2C controller driving the LM75 target against a register-image model.
module tb_lm75_i2c_target;
    localparam int Q = 100;

    logic        clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic [15:0] temp_in = 16'h0000;
    logic        sda_line, sda_oe, busy, watch = 1'b0, saw_oe;
    logic [7:0]  cfg_out;
    int          vectors = 0, errors = 0;
    logic [1:0]  m_ptr = 2'd0;
    logic [7:0]  m_cfg = 8'h00;
    logic [15:0] m_tos = 16'h5000, m_thyst = 16'h4B00;
    logic [7:0]  wbuf [8];

    assign sda_line = sda_m & ~sda_oe;
    always #5 clk = ~clk;
    always @(posedge clk) saw_oe <= watch ? (saw_oe | sda_oe) : 1'b0;

    lm75_i2c_target dut (
        .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .temp_in(temp_in), .cfg_out(cfg_out), .busy(busy)
    );

    task automatic bus_start;
        sda_m = 1; #Q; scl = 1; #Q; sda_m = 0; #Q; scl = 0; #Q;
    endtask

    task automatic bus_stop;
        sda_m = 0; #Q; scl = 1; #Q; sda_m = 1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q; scl = 1; #(2*Q); scl = 0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1; #Q; scl = 1; #Q; b = sda_line; #Q; scl = 0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_n);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack, input logic chg, input logic [15:0] nt);
        logic x;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(x);
            b = {b[6:0], x};
            if (chg && i == 3) temp_in = nt;
        end
        send_bit(nack);
    endtask

    task automatic model_write(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) m_ptr = wbuf[0][1:0];
            else if (i == 1 && m_ptr == 2'd1) m_cfg = wbuf[1];
            else if (i == 2 && m_ptr == 2'd2) m_thyst = {wbuf[1], wbuf[2]};
            else if (i == 2 && m_ptr == 2'd3) m_tos = {wbuf[1], wbuf[2]};
        end
    endtask

    task automatic wr_txn(input int n);
        logic a;
        bus_start;
        write_byte(8'h90, a);
        vectors++;
        if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", a); end
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a);
            vectors++;
            if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack[%0d]: got %b want 0", i, a); end
        end
        model_write(n);
    endtask

    task automatic rd_txn(input int n, input logic chg, input logic [15:0] nt);
        logic a;
        logic [7:0] b;
        logic [15:0] w;
        logic [7:0] img [$];
        w = (m_ptr == 2'd0) ? temp_in : (m_ptr == 2'd2) ? m_thyst : m_tos;
        img.delete();
        if (m_ptr == 2'd1) img.push_back(m_cfg);
        else begin img.push_back(w[15:8]); img.push_back(w[7:0]); end
        bus_start;
        write_byte(8'h91, a);
        vectors++;
        if (a !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rd_addr_ack: ack_n=%b busy=%b want 0/1", a, busy);
        end
        for (int i = 0; i < n; i++) begin
            read_byte(b, i == n - 1, chg && i == 0, nt);
            vectors++;
            if (b !== img[i % img.size()]) begin
                errors++; $display("FAIL rd_data[%0d] ptr=%0d: got %h want %h", i, m_ptr, b, img[i % img.size()]);
            end
        end
        vectors++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_release: sda_oe=%b busy=%b want 0/0", sda_oe, busy);
        end
    endtask

    task automatic test_reset;
        #22;
        vectors++;
        if (sda_oe !== 1'b0 || busy !== 1'b0 || cfg_out !== 8'h00) begin
            errors++; $display("FAIL reset_state: sda_oe=%b busy=%b cfg=%h want 0/0/00", sda_oe, busy, cfg_out);
        end
        reset = 0;
        #Q;
        wbuf[0] = 8'h02;
        wr_txn(1);
        rd_txn(2, 0, 16'h0);
        bus_stop;
    endtask

    task automatic test_temp_read;
        temp_in = 16'h1980;
        wbuf[0] = 8'h00;
        wr_txn(1);
        rd_txn(2, 0, 16'h0);
        bus_stop;
    endtask

    task automatic test_tos_write;
        wbuf[0] = 8'h03; wbuf[1] = 8'h55; wbuf[2] = 8'h00;
        wr_txn(3);
        bus_stop;
        rd_txn(2, 0, 16'h0);
        bus_stop;
    endtask

    task automatic test_bad_addr;
        logic a;
        watch = 1;
        bus_start;
        write_byte(8'h92, a);
        vectors++;
        if (a !== 1'b1) begin errors++; $display("FAIL bad_addr_nack: got %b want 1", a); end
        write_byte(8'h5A, a);
        vectors++;
        if (a !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_addr_ignore: ack_n=%b busy=%b want 1/0", a, busy);
        end
        bus_stop;
        #Q;
        vectors++;
        if (saw_oe !== 1'b0) begin errors++; $display("FAIL bad_addr_sda: sda_oe seen %b want 0", saw_oe); end
        watch = 0;
        rd_txn(2, 0, 16'h0);
        bus_stop;
    endtask

    task automatic test_cfg;
        wbuf[0] = 8'h01; wbuf[1] = 8'h06;
        wr_txn(2);
        vectors++;
        if (cfg_out !== 8'h06) begin errors++; $display("FAIL cfg_write: got %h want 06", cfg_out); end
        bus_stop;
        rd_txn(4, 0, 16'h0);
        bus_stop;
    endtask

    task automatic test_snapshot;
        temp_in = 16'h1980;
        wbuf[0] = 8'h00;
        wr_txn(1);
        bus_stop;
        rd_txn(2, 1, 16'h0000);
        bus_stop;
    endtask

    task automatic test_random;
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                wr_txn($urandom_range(1, 4));
            end else begin
                temp_in = 16'($urandom);
                rd_txn($urandom_range(1, 4), 1'($urandom), 16'($urandom));
            end
            bus_stop;
        end
    endtask

    task automatic test_reset_mid;
        logic a, x;
        wbuf[0] = 8'h01; wbuf[1] = 8'h06;
        wr_txn(2);
        bus_stop;
        bus_start;
        write_byte(8'h91, a);
        for (int i = 0; i < 3; i++) get_bit(x);
        sda_m = 1; #Q; scl = 1; #Q;
        vectors++;
        if (sda_oe !== 1'b1) begin errors++; $display("FAIL pre_reset_drive: got %b want 1", sda_oe); end
        reset = 1;
        #10;
        vectors++;
        if (sda_oe !== 1'b0 || cfg_out !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: sda_oe=%b cfg=%h busy=%b want 0/00/0", sda_oe, cfg_out, busy);
        end
        #(Q - 10);
        reset = 0;
        scl = 0;
        #Q;
        for (int i = 0; i < 4; i++) get_bit(x);
        send_bit(1);
        bus_stop;
        m_ptr = 2'd0; m_cfg = 8'h00; m_tos = 16'h5000; m_thyst = 16'h4B00;
        temp_in = 16'h2A40;
        rd_txn(2, 0, 16'h0);
        bus_stop;
        wbuf[0] = 8'h03;
        wr_txn(1);
        rd_txn(2, 0, 16'h0);
        bus_stop;
    endtask

    initial begin
        #2;
        test_reset;
        test_temp_read;
        test_tos_write;
        test_bad_addr;
        test_cfg;
        test_snapshot;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/lm75_i2c_target.md
LM75_I2C_TARGET -- requirements
Module: lm75_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b1001000, the 7-bit I2C target address.
REQ-002 SHALL have parameter TOS_RST, default 16'h5000, the reset value of the TOS register (80 C).
REQ-003 SHALL have parameter THYST_RST, default 16'h4B00, the reset value of the THYST register (75 C).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port scl_i  input  1  raw I2C SCL line, asynchronous to clk.
REQ-007 SHALL have port sda_i  input  1  raw I2C SDA line, asynchronous to clk.
REQ-008 SHALL have port sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain; the top-level ties the pad).
REQ-009 SHALL have port temp_in  input  16  live temperature word, LM75 format, MSB-aligned.
REQ-010 SHALL have port cfg_out  output  8  current configuration register.
REQ-011 SHALL have port busy  output  1  high from an address-matched START until STOP or NACK-release.

Function
REQ-012 SHALL pass scl_i and sda_i through 2-flop synchronizers and detect rise/fall edges on the synchronized values; the design requires clk >= 20x SCL frequency.
REQ-013 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as an SDA rise while SCL is high; both are recognized in every state.
REQ-014 SHALL sample SDA on the SCL rising edge and change sda_oe only on the clk cycle after an SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-016 SHALL go IDLE->ADDR on START, and go ->ADDR from any state on a repeated START, clearing the bit counter.
REQ-017 SHALL go ->IDLE from any state on STOP, with sda_oe=0 and busy=0 on the next cycle.
REQ-018 In ADDR, SHALL shift in 8 bits MSB first; on an address match it SHALL go to ADDR_ACK, otherwise to WAIT_STOP with sda_oe held at 0.
REQ-019 In ADDR_ACK, SHALL drive sda_oe=1 from the 8th SCL fall to the 9th SCL fall, then go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1).
REQ-020 SHALL treat the first write byte after the address as the pointer (bits[1:0]: 0 temp, 1 config, 2 THYST, 3 TOS); bits[7:2] SHALL be ignored.
REQ-021 SHALL handle subsequent write bytes as follows:
- config: written on its ACK.
- THYST/TOS: MSB then LSB, both bytes committed atomically on the LSB ACK.
- temp: discarded.
- bytes beyond the register width: discarded.
REQ-022 SHALL ACK every write byte (WR_ACK: sda_oe=1 for the 9th clock).
REQ-023 SHALL snapshot temp_in into a 16-bit holding register at the R/W-bit sample of a matched read, so both read bytes are coherent.
REQ-024 In RD_BYTE, SHALL drive the selected register MSB first; sda_oe = ~bit, and bit 7 is set up after the ACK-clock fall.
REQ-025 SHALL return data from the pointer: 16-bit registers as MSB, LSB, MSB, ... (wrapping); config as the same byte repeated.
REQ-026 In RD_ACK, SHALL release SDA and sample the controller's bit: 0 (ACK) -> next byte; 1 (NACK) -> WAIT_STOP.
REQ-027 SHALL keep the pointer across transactions, so a read without a pointer write uses the last pointer.
REQ-028 SHALL never drive sda_oe=1 while SCL is high, except during an ACK bit or a data 0 bit it owns.

Reset
REQ-029 On reset SHALL force:
- state IDLE, sda_oe=0, busy=0.
- pointer=0, cfg_out=8'h00.
- TOS=TOS_RST, THYST=THYST_RST, temp snapshot=16'h0000.
- synchronizers to 1 (bus idle).
REQ-030 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously), and the block SHALL wait for a fresh START.

Verification
REQ-031 temp_in=16'h1980, write pointer 0x00, repeated START, read 2 bytes with ACK then NACK -> bytes 0x19, 0x80; sda_oe=0 after NACK.
REQ-032 Write {0x90, 0x03, 0x55, 0x00}, STOP, then read 2 bytes -> 0x55, 0x00; a read of pointer 2 after reset -> 0x4B, 0x00.
REQ-033 Address 0x49 (write) -> no ACK (SDA high at the 9th clock); bus ignored until STOP; a following 0x91 read succeeds.
REQ-034 Write pointer 0x01 then data 0x06 -> cfg_out=8'h06 on the cycle after the ACK clock; a 4-byte read returns 0x06 x4.
REQ-035 temp_in changes from 16'h1980 to 16'h0000 between MSB and LSB of a read -> bytes 0x19, 0x80 (snapshot holds).
REQ-036 Assert reset during the 4th data bit of a read -> sda_oe=0 within 1 cycle, cfg_out=0, TOS=0x5000; the next transaction behaves normally.
